seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial pattern detector, the successor to the fixed 5-state detector. It samples one bit of `seq` per enabled clock and pulses `flag` when the last `N` sampled bits equal `PATTERN`. Overlapping or non-overlapping matching is selected at run time, and an optional saturating hit counter is provided. It sits directly on a serial bit stream and feeds control logic that consumes single-cycle match pulses.

## Interface
- `N`, default 5: pattern length in bits; legal range 2..32.
- `PATTERN`, default 5'b10010: target sequence, `N` bits wide. MSB is the first bit received.
- `CNT_W`, default 8: hit-counter width; legal range 1..16.
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `en` input 1: bit-valid; `seq` is sampled only when `en`=1.
- `seq` input 1: serial data bit.
- `overlap` input 1: 1 = overlapping matches, 0 = non-overlapping; sampled every enabled edge.
- `clr` input 1: synchronous clear of history, flag and counter.
- `flag` output 1: registered single-cycle match pulse.
- `hit_cnt` output CNT_W: number of matches since the last reset/clr, saturating.

## Operation
- State:
  - `hist[N-1:0]`: shift register of received bits; newest bit in the LSB.
  - `fill`: 0..N, the count of valid bits in `hist`.
  - `flag` register.
  - `hit_cnt` register.
- Reset (`reset`=0, asynchronous): `hist`=0, `fill`=0, `flag`=0, `hit_cnt`=0, all immediately.
- Priority on each rising edge: `clr` > `en` > hold.
- `clr`=1: `hist`=0, `fill`=0, `flag`=0, `hit_cnt`=0. Any `seq`/`en` in that cycle is discarded.
- `en`=0: `hist`, `fill` and `hit_cnt` hold; `flag`<=0.
- `en`=1:
  - `nh` = {hist[N-2:0], seq}; `nf` = min(fill+1, N).
  - `match` = (nf==N) && (nh==PATTERN).
  - `hist`<=nh; `flag`<=match.
  - If `match` and `overlap`=0, then `fill`<=0 (history invalidated; a new match needs N fresh bits). Otherwise `fill`<=nf.
  - If `match`, `hit_cnt`<=hit_cnt+1, saturating at 2^CNT_W-1 (no wrap).
- A pattern whose bits are all equal (e.g. 11111) in overlap mode flags on every enabled bit once `fill`=N.
- `overlap` may change mid-stream. It takes effect at the next match evaluation; past history is never re-scanned.
- Bits with `en`=0 are skipped, not treated as zeros. Matches span enable gaps.

## Timing
- Latency: `flag` goes high on the same rising edge that samples the final pattern bit. It is visible for exactly one cycle after that edge.
- `hit_cnt` increments on the same edge that `flag` rises. Both are registered, with no combinational path from inputs.
- Back-to-back flags are possible, only in overlap mode with a self-overlapping pattern.
- Reset asserted mid-pattern: a partial match is lost. After `reset` deasserts, N fresh enabled bits are needed before any flag.
- `clr` together with a would-be match: no flag, `hit_cnt`=0.
- Minimum throughput: one bit per clock; no stall or backpressure.

## Configuration
- Macro `SEQ_DETECT_HITCNT_EN`:
  - Defined: the counter logic described above is built.
  - Undefined: no counter register is built; `hit_cnt` is tied to constant 0. The port remains so the interface is identical.
- `flag` behaviour is identical in both builds.

## Test plan
All scenarios use default parameters and `SEQ_DETECT_HITCNT_EN` defined, unless noted.
- Overlap: `overlap`=1, `en`=1, seq = 1,0,0,1,0,0,1,0 → `flag` pulses after bits 5 and 8; `hit_cnt`=2.
- Non-overlap: same stream with `overlap`=0 → `flag` only after bit 5; `hit_cnt`=1.
- Enable gaps: stream 1,0,0,1,0 with `en`=0 for 3 cycles between bits 2 and 3 → single flag after bit 5. `flag` stays 0 during the gaps.
- Reset and clear: `reset` pulsed low after bits 1,0,0,1, then 0,1,0,0,1,0 → no flag until the final 0 of 10010; all outputs 0 during reset. Separately, `clr`=1 on the final-bit edge → no flag, `hit_cnt`=0.
- Saturation: `CNT_W`=2, `PATTERN`=2'b11, `N`=2, overlap, seq = six 1s → 5 flags; `hit_cnt` reaches 3 and holds at 3.
- Macro off: build without `SEQ_DETECT_HITCNT_EN`, run the overlap scenario → same `flag` pulses; `hit_cnt` = 0 throughout.

Source files
------------

// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial pattern detector.
// Shifts one bit of seq into a history register per enabled clock and pulses
// flag for one cycle when the last N valid bits equal PATTERN (MSB first).
// Overlapping or non-overlapping matching is chosen at run time by overlap.
// Build option: define SEQ_DETECT_HITCNT_EN to build the saturating hit
// counter; without it hit_cnt is tied to zero and the port is kept.
//
// The design has no state machine. Its only sequencing state is fill, which
// counts the valid bits in hist from 0 up to N.
module seq_detect_param #(
    parameter int            N       = 5,
    parameter logic [N-1:0]  PATTERN = 5'b10010,
    parameter int            CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             seq,
    input  logic             overlap,
    input  logic             clr,
    output logic             flag,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int FILL_W = $clog2(N + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);

    logic [N-1:0]      hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              flag_q, flag_d;

    logic [N-1:0]      nh;
    logic [FILL_W-1:0] nf;
    logic              match;

    // Candidate history and fill after taking in the current bit.
    always_comb begin
        nh    = {hist_q[N-2:0], seq};
        nf    = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
        match = (nf == FILL_FULL) && (nh == PATTERN);
    end

    // Next-state for history, fill and flag: clr beats en, en beats hold.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        flag_d = 1'b0;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = nh;
            flag_d = match;
            // Non-overlapping: a hit consumes the history, so the next hit
            // needs N fresh bits.
            fill_d = (match && !overlap) ? '0 : nf;
        end
    end

    // History, fill and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
            flag_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            flag_q <= flag_d;
        end
    end

    assign flag = flag_q;

`ifdef SEQ_DETECT_HITCNT_EN
    logic [CNT_W-1:0] hit_q, hit_d;
    logic             hit_inc;

    assign hit_inc = !clr && en && match;

    // Saturating hit counter; it stops at all-ones and does not wrap.
    always_comb begin
        hit_d = hit_q;
        if (clr) begin
            hit_d = '0;
        end else if (hit_inc && (hit_q != '1)) begin
            hit_d = hit_q + CNT_W'(1);
        end
    end

    // Hit counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_cnt = hit_q;
`else
    assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default instance (N=5, 10010) plus a
// small N=2, 11, CNT_W=2 instance for counter saturation. Expected hit_cnt
// values collapse to zero when SEQ_DETECT_HITCNT_EN is not defined.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, seq, overlap, clr;
    logic       flag;
    logic [7:0] hit_cnt;

    logic       en2, seq2, clr2;
    logic       flag2;
    logic [1:0] hit_cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_detect_param u_dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .seq     (seq),
        .overlap (overlap),
        .clr     (clr),
        .flag    (flag),
        .hit_cnt (hit_cnt)
    );

    seq_detect_param #(.N(2), .PATTERN(2'b11), .CNT_W(2)) u_sat (
        .clk     (clk),
        .reset   (reset),
        .en      (en2),
        .seq     (seq2),
        .overlap (1'b1),
        .clr     (clr2),
        .flag    (flag2),
        .hit_cnt (hit_cnt2)
    );

    // Expected counter value for the active build.
    function automatic int hc(input int n);
`ifdef SEQ_DETECT_HITCNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one clock of the main instance and sample 1 ns after the edge.
    task automatic step(input logic e, input logic s, input logic c);
        en  = e;
        seq = s;
        clr = c;
        @(posedge clk);
        #1;
        en  = 1'b0;
        clr = 1'b0;
    endtask

    task automatic step2(input logic e, input logic s);
        en2  = e;
        seq2 = s;
        @(posedge clk);
        #1;
        en2 = 1'b0;
    endtask

    // Feed a 0/1 string on the main instance, checking flag after each bit.
    task automatic feed(input string tag, input string bits, input string flags);
        for (int i = 0; i < bits.len(); i++) begin
            step(1'b1, bits[i] == "1", 1'b0);
            chk($sformatf("%s_flag%0d", tag, i + 1), int'(flag), int'(flags[i] == "1"));
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; seq = 1'b0; overlap = 1'b1; clr = 1'b0;
        en2 = 1'b0; seq2 = 1'b0; clr2 = 1'b0;

        // Reset state
        #12;
        chk("rst_flag", int'(flag), 0);
        chk("rst_hit",  int'(hit_cnt), 0);
        chk("rst_flag2", int'(flag2), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Overlapping matches: flags after bits 5 and 8
        overlap = 1'b1;
        feed("ovl", "10010", "00001");
        chk("ovl_hit5", int'(hit_cnt), hc(1));
        feed("ovl_b", "010", "001");
        chk("ovl_hit8", int'(hit_cnt), hc(2));

        step(1'b0, 1'b0, 1'b1);
        chk("clr1_flag", int'(flag), 0);
        chk("clr1_hit",  int'(hit_cnt), 0);

        // Non-overlapping: only the first match counts
        overlap = 1'b0;
        feed("novl", "10010010", "00001000");
        chk("novl_hit", int'(hit_cnt), hc(1));

        step(1'b0, 1'b0, 1'b1);
        chk("clr2_hit", int'(hit_cnt), 0);

        // Enable gaps are skipped, not read as zeros
        overlap = 1'b1;
        feed("gap_a", "10", "00");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk($sformatf("gap_idle%0d", i), int'(flag), 0);
        end
        feed("gap_b", "010", "001");
        chk("gap_hit", int'(hit_cnt), hc(1));
        step(1'b0, 1'b0, 1'b0);
        chk("gap_after_flag", int'(flag), 0);
        chk("gap_hit_hold", int'(hit_cnt), hc(1));

        // Reset mid-pattern: partial match lost, clears asynchronously
        feed("rstm_a", "1001", "0000");
        #2;
        reset = 1'b0;
        #1;
        chk("rstm_async_hit", int'(hit_cnt), 0);
        chk("rstm_async_flag", int'(flag), 0);
        step(1'b1, 1'b0, 1'b0);
        chk("rstm_held_flag", int'(flag), 0);
        reset = 1'b1;
        feed("rstm_b", "010010", "000001");
        chk("rstm_hit", int'(hit_cnt), hc(1));

        // clr on the would-be final bit wins
        feed("clrm", "1001", "0000");
        step(1'b1, 1'b0, 1'b1);
        chk("clrm_flag", int'(flag), 0);
        chk("clrm_hit",  int'(hit_cnt), 0);
        step(1'b1, 1'b0, 1'b0);
        chk("clrm_after_flag", int'(flag), 0);

        // Saturation on the N=2 / 11 / CNT_W=2 instance
        for (int i = 0; i < 6; i++) begin
            step2(1'b1, 1'b1);
            chk($sformatf("sat_flag%0d", i + 1), int'(flag2), (i == 0) ? 0 : 1);
            chk($sformatf("sat_hit%0d", i + 1), int'(hit_cnt2), hc((i < 3) ? i : 3));
        end
        step2(1'b0, 1'b0);
        chk("sat_idle_flag", int'(flag2), 0);
        chk("sat_idle_hit",  int'(hit_cnt2), hc(3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
